fifo_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the CPU-to-FPGA async FIFO between NUM_REQ requesters on the write clock domain.
- Grants one requester at a time for a burst of up to MAX_BURST beats, or until its last beat.
- Tags each word with the requester ID in the upper bits so the read side can demultiplex.
- Drives the FIFO data_in/w_en pair and consumes its full flag.

---
 rtl/fifo_write_arbiter.sv | 145 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin owner of the async FIFO write port. A requester is granted after
// one IDLE cycle of arbitration and keeps the port for up to MAX_BURST beats,
// until its last beat, or until it bubbles (no valid while the FIFO has room).
// Each FIFO word carries the owner ID above the payload so that the read side
// can demultiplex the packets.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int WIDTH      = 34,
    parameter int MAX_BURST  = 4
) (
    input  logic                          w_clk,
    input  logic                          w_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [WIDTH-1:0]              fifo_data_in,
    output logic                          fifo_w_en,
    input  logic                          fifo_full,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    if (WIDTH != DATA_WIDTH + ID_WIDTH) begin : g_width_check
        $error("fifo_write_arbiter: WIDTH must equal DATA_WIDTH + ID_WIDTH");
    end
    if (NUM_REQ < 2) begin : g_num_req_check
        $error("fifo_write_arbiter: NUM_REQ must be at least 2");
    end
    if (MAX_BURST < 1) begin : g_burst_check
        $error("fifo_write_arbiter: MAX_BURST must be at least 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] owner_q, owner_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                pick_found;
    logic [ID_WIDTH-1:0] pick_idx;
    logic [ID_WIDTH-1:0] cand_idx;
    int                  cand;
    logic                beat_fire;

    // Split the flat payload bus into one slice per requester.
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Zero-latency data path: the owner tag sits above the owner's payload.
    assign fifo_data_in = {owner_q, req_data_arr[owner_q]};
    assign grant_id     = owner_q;
    assign busy         = (state_q == BURST);

    // Round-robin search: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        // NOTE: every signal written here gets a default first; any path that
        // leaves one unassigned would infer a latch.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = ID_WIDTH'(cand);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Next-state logic plus the handshake outputs toward requesters and FIFO.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        req_ready  = '0;
        fifo_w_en  = 1'b0;
        beat_fire  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                req_ready[owner_q] = !fifo_full;
                beat_fire          = req_valid[owner_q] && !fifo_full;
                fifo_w_en          = beat_fire;
                if (beat_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (req_last[owner_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
                    end
                end else if (!fifo_full) begin
                    // Owner has nothing to send while the FIFO has room: give up the port.
                    state_d  = IDLE;
                    rr_ptr_d = (int'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
                end
                // FIFO full: hold grant and count, the pending beat is retried.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with asynchronous active-high reset.
    always_ff @(posedge w_clk or posedge w_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (w_rst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: directed vector table, hand-written
// multi-cycle sequences, and a randomized run against a behavioural model.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ID_WIDTH   = 2;
    localparam int WIDTH      = 34;
    localparam int MAX_BURST  = 4;
    localparam int RAND_CYCLES = 3000;

    logic                          w_clk = 1'b0;
    logic                          w_rst;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [WIDTH-1:0]              fifo_data_in;
    logic                          fifo_w_en;
    logic                          fifo_full;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    int n_vec = 0;
    int n_err = 0;

    fifo_write_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .ID_WIDTH  (ID_WIDTH),
        .WIDTH     (WIDTH),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .w_clk       (w_clk),
        .w_rst       (w_rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_data_in(fifo_data_in),
        .fifo_w_en   (fifo_w_en),
        .fifo_full   (fifo_full),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 w_clk = ~w_clk;

    typedef struct {
        logic [NUM_REQ-1:0]    valid;
        logic [NUM_REQ-1:0]    last;
        logic                  full;
        logic [DATA_WIDTH-1:0] d;
        logic                  wen;
        logic [NUM_REQ-1:0]    ready;
        logic [ID_WIDTH-1:0]   grant;
        logic                  bsy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [31:0] d, input logic we, input logic [3:0] r,
                       input logic [1:0] g, input logic b);
        vec_t e;
        e.valid = v; e.last = l; e.full = f; e.d = d;
        e.wen = we; e.ready = r; e.grant = g; e.bsy = b;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic we, input logic [3:0] r,
                              input logic [1:0] g, input logic b);
        check({tag, ".w_en"},     64'(fifo_w_en), 64'(we));
        check({tag, ".ready"},    64'(req_ready), 64'(r));
        check({tag, ".grant_id"}, 64'(grant_id),  64'(g));
        check({tag, ".busy"},     64'(busy),      64'(b));
    endtask

    task automatic set_all_data(input logic [31:0] d);
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = d;
    endtask

    function automatic logic [31:0] tag_data(input int i);
        return 32'h1000_0000 * i + 32'h0000_BEEF;
    endfunction

    task automatic set_tagged_data();
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_WIDTH +: DATA_WIDTH] = tag_data(i);
    endtask

    // Leaves reset released at a falling edge with all inputs idle.
    task automatic do_reset();
        w_rst = 1'b1;
        req_valid = '0; req_last = '0; fifo_full = 1'b0; set_all_data('0);
        @(negedge w_clk);
        @(negedge w_clk);
        w_rst = 1'b0;
    endtask

    // Behavioural model state for the randomized run.
    bit                    m_busy;
    int                    m_owner, m_cnt, m_rr;
    bit                    src_valid [NUM_REQ];
    bit                    src_last  [NUM_REQ];
    logic [DATA_WIDTH-1:0] src_data  [NUM_REQ];
    bit                    acc       [NUM_REQ];

    initial begin
        // ---------------- directed vector table ----------------
        add(4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(4'b0100, 4'b0000, 1'b0, 32'hA5A5_0001, 1'b0, 4'b0000, 2'd0, 1'b0);
        add(4'b0100, 4'b0000, 1'b0, 32'hA5A5_0001, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0000, 1'b0, 32'hA5A5_0002, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0000, 1'b0, 32'hA5A5_0003, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(4'b0100, 4'b0100, 1'b0, 32'hA5A5_0004, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 4'b0000, 2'd2, 1'b0);
        add(4'b1110, 4'b1110, 1'b0, 32'hC0DE_0003, 1'b0, 4'b0000, 2'd2, 1'b0);
        add(4'b1110, 4'b1110, 1'b0, 32'hC0DE_0003, 1'b1, 4'b1000, 2'd3, 1'b1);
        add(4'b0110, 4'b0000, 1'b0, 32'hC0DE_0001, 1'b0, 4'b0000, 2'd3, 1'b0);
        add(4'b0110, 4'b0000, 1'b0, 32'hC0DE_0001, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(4'b0110, 4'b0000, 1'b1, 32'hC0DE_0002, 1'b0, 4'b0000, 2'd1, 1'b1);
        add(4'b0110, 4'b0000, 1'b1, 32'hC0DE_0002, 1'b0, 4'b0000, 2'd1, 1'b1);
        add(4'b0110, 4'b0000, 1'b1, 32'hC0DE_0002, 1'b0, 4'b0000, 2'd1, 1'b1);
        add(4'b0110, 4'b0000, 1'b0, 32'hC0DE_0002, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(4'b0110, 4'b0000, 1'b0, 32'hC0DE_0003, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(4'b0110, 4'b0000, 1'b0, 32'hC0DE_0004, 1'b1, 4'b0010, 2'd1, 1'b1);
        add(4'b0110, 4'b0000, 1'b0, 32'hC0DE_0005, 1'b0, 4'b0000, 2'd1, 1'b0);
        add(4'b0110, 4'b0100, 1'b1, 32'hC0DE_0006, 1'b0, 4'b0000, 2'd2, 1'b1);
        add(4'b0110, 4'b0100, 1'b0, 32'hC0DE_0006, 1'b1, 4'b0100, 2'd2, 1'b1);
        add(4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0, 4'b0000, 2'd2, 1'b0);

        do_reset();
        #1;
        check_outs("reset", 1'b0, 4'b0000, 2'd0, 1'b0);
        check("reset.data", 64'(fifo_data_in), 64'({2'd0, 32'h0000_0000}));

        foreach (tbl[n]) begin
            @(negedge w_clk);
            req_valid = tbl[n].valid;
            req_last  = tbl[n].last;
            fifo_full = tbl[n].full;
            set_all_data(tbl[n].d);
            #1;
            check_outs($sformatf("tbl[%0d]", n), tbl[n].wen, tbl[n].ready, tbl[n].grant, tbl[n].bsy);
            check($sformatf("tbl[%0d].data", n), 64'(fifo_data_in), 64'({tbl[n].grant, tbl[n].d}));
        end

        // ---------------- all requesters streaming, no last ----------------
        do_reset();
        set_tagged_data();
        req_valid = 4'b1111;
        #1;
        check_outs("rr.idle0", 1'b0, 4'b0000, 2'd0, 1'b0);
        for (int b = 0; b < 5; b++) begin
            for (int k = 0; k < MAX_BURST; k++) begin
                @(negedge w_clk); #1;
                check_outs($sformatf("rr.g%0d.b%0d", b, k), 1'b1, 4'(1 << (b % 4)), 2'(b % 4), 1'b1);
                check($sformatf("rr.g%0d.data", b), 64'(fifo_data_in), 64'({2'(b % 4), tag_data(b % 4)}));
            end
            if (b < 4) begin
                @(negedge w_clk); #1;
                check_outs($sformatf("rr.gap%0d", b), 1'b0, 4'b0000, 2'(b % 4), 1'b0);
            end
        end

        // ---------------- bubble release by owner 3 ----------------
        do_reset();
        set_tagged_data();
        req_valid = 4'b1000;
        #1;
        check_outs("bub.idle", 1'b0, 4'b0000, 2'd0, 1'b0);
        @(negedge w_clk); #1;
        check_outs("bub.beat1", 1'b1, 4'b1000, 2'd3, 1'b1);
        @(negedge w_clk); #1;
        check_outs("bub.beat2", 1'b1, 4'b1000, 2'd3, 1'b1);
        @(negedge w_clk);
        req_valid = 4'b0011;
        #1;
        check_outs("bub.bubble", 1'b0, 4'b1000, 2'd3, 1'b1);
        @(negedge w_clk); #1;
        check_outs("bub.release", 1'b0, 4'b0000, 2'd3, 1'b0);
        @(negedge w_clk); #1;
        check_outs("bub.regrant", 1'b1, 4'b0001, 2'd0, 1'b1);

        // ---------------- asynchronous reset mid-burst ----------------
        do_reset();
        set_tagged_data();
        req_valid = 4'b0100;
        #1;
        @(negedge w_clk); #1;
        check_outs("arst.beat1", 1'b1, 4'b0100, 2'd2, 1'b1);
        @(negedge w_clk); #1;
        check_outs("arst.beat2", 1'b1, 4'b0100, 2'd2, 1'b1);
        #1;
        w_rst = 1'b1;
        #1;
        check_outs("arst.in_reset", 1'b0, 4'b0000, 2'd0, 1'b0);
        @(negedge w_clk);
        w_rst = 1'b0;
        req_valid = 4'b0110;
        #1;
        check_outs("arst.idle", 1'b0, 4'b0000, 2'd0, 1'b0);
        @(negedge w_clk); #1;
        check_outs("arst.regrant", 1'b1, 4'b0010, 2'd1, 1'b1);

        // ---------------- randomized run against the model ----------------
        do_reset();
        m_busy = 1'b0; m_owner = 0; m_cnt = 0; m_rr = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_valid[i] = 1'b0; src_last[i] = 1'b0; src_data[i] = '0; acc[i] = 1'b0;
        end
        for (int c = 0; c < RAND_CYCLES; c++) begin
            logic [NUM_REQ-1:0] exp_ready;
            logic               exp_wen;
            @(negedge w_clk);
            // Requesters: a beat stays put until accepted, then may be replaced.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] || !src_valid[i]) begin
                    if (acc[i] || ($urandom_range(0, 1) == 0)) begin
                        src_valid[i] = ($urandom_range(0, 2) != 0);
                        src_last[i]  = ($urandom_range(0, 3) == 0);
                        src_data[i]  = $urandom;
                    end
                end
                req_valid[i] = src_valid[i];
                req_last[i]  = src_last[i];
                req_data[i*DATA_WIDTH +: DATA_WIDTH] = src_data[i];
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            #1;

            exp_ready = '0;
            exp_wen   = 1'b0;
            if (m_busy) begin
                exp_ready[m_owner] = !fifo_full;
                exp_wen = src_valid[m_owner] && !fifo_full;
            end
            check_outs($sformatf("rnd[%0d]", c), exp_wen, exp_ready, 2'(m_owner), m_busy);
            check($sformatf("rnd[%0d].data", c), 64'(fifo_data_in),
                  64'({2'(m_owner), src_data[m_owner]}));

            for (int i = 0; i < NUM_REQ; i++) acc[i] = src_valid[i] && exp_ready[i];

            // Advance the model across the coming rising edge.
            if (!m_busy) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!m_busy && src_valid[(m_rr + k) % NUM_REQ]) begin
                        m_owner = (m_rr + k) % NUM_REQ;
                        m_cnt   = 0;
                        m_busy  = 1'b1;
                    end
                end
            end else if (!fifo_full) begin
                if (src_valid[m_owner]) begin
                    m_cnt++;
                    if (src_last[m_owner] || m_cnt == MAX_BURST) begin
                        m_busy = 1'b0;
                        m_rr   = (m_owner + 1) % NUM_REQ;
                    end
                end else begin
                    m_busy = 1'b0;
                    m_rr   = (m_owner + 1) % NUM_REQ;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
